uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 114 +++++++++++
 tb/tb_uart_tx_serializer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// One serial bit per CLK cycle; TX_OUT and Busy come straight from flops.
module uart_tx_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             DATA_VALID,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic             TX_OUT,
    output logic             Busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             par_en_q, par_en_d;
    logic             par_bit_q, par_bit_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next state, so they change only on the clock edge
    // (or asynchronously to idle levels on reset).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    state_d   = StStart;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StParity: state_d = StStop;
            StStop:   state_d = StIdle;
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            StIdle:   busy_d = 1'b0;
            StStart:  tx_d   = 1'b0;
            StData:   tx_d   = data_q[cnt_d];
            StParity: tx_d   = par_bit_q;
            StStop:   tx_d   = 1'b1;
            default:  busy_d = 1'b0;
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: hand-computed frames checked bit by bit.
module tb_uart_tx_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Sends one frame and checks each line bit; exp lists bits in transmit order.
    task automatic send(input string tag, input logic [7:0] d, input logic pen,
                        input logic pt, input int n, input logic [0:10] exp,
                        input logic [7:0] alt, input int pulse_at);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        tick();
        P_DATA     = alt;
        PAR_EN     = ~pen;
        PAR_TYP    = ~pt;
        DATA_VALID = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s tx[%0d]", tag, i), TX_OUT, exp[i]);
            chk($sformatf("%s busy[%0d]", tag, i), Busy, 1'b1);
            DATA_VALID = (i == pulse_at);
            if (i == pulse_at) P_DATA = 8'h3C;
            tick();
        end
        DATA_VALID = 1'b0;
        chk($sformatf("%s idle tx", tag), TX_OUT, 1'b1);
        chk($sformatf("%s idle busy", tag), Busy, 1'b0);
    endtask

    initial begin
        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #12;
        chk("reset tx", TX_OUT, 1'b1);
        chk("reset busy", Busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;

        send("a5_nopar", 8'hA5, 1'b0, 1'b0, 10, 11'b0_10100101_1_1, 8'h00, -1);
        send("a5_even", 8'hA5, 1'b1, 1'b0, 11, 11'b0_10100101_0_1, 8'h00, -1);
        send("a5_odd", 8'hA5, 1'b1, 1'b1, 11, 11'b0_10100101_1_1, 8'h00, -1);
        send("07_even", 8'h07, 1'b1, 1'b0, 11, 11'b0_11100000_1_1, 8'hFF, -1);

        // DATA_VALID pulse mid-frame must be ignored and must not queue a frame.
        send("a5_pulse", 8'hA5, 1'b0, 1'b0, 10, 11'b0_10100101_1_1, 8'h00, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("no_second_frame busy[%0d]", i), Busy, 1'b0);
            chk($sformatf("no_second_frame tx[%0d]", i), TX_OUT, 1'b1);
        end

        // Reset during the 4th data bit aborts the frame without a clock edge.
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        repeat (4) tick();
        chk("pre_abort busy", Busy, 1'b1);
        #1;
        RST = 1'b0;
        #1;
        chk("abort tx", TX_OUT, 1'b1);
        chk("abort busy", Busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        send("55_after_rst", 8'h55, 1'b0, 1'b0, 10, 11'b0_10101010_1_1, 8'h00, -1);

        // Held DATA_VALID: 10 busy cycles, exactly one idle cycle, then the next frame.
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        tick();
        for (int i = 0; i < 22; i++) begin
            chk($sformatf("held busy[%0d]", i), Busy, (i % 11) != 10);
            tick();
        end
        DATA_VALID = 1'b0;
        for (int k = 0; k < 40 && Busy; k++) tick();
        chk("held drain busy", Busy, 1'b0);
        tick();

        // Upstream controller sending a 16-bit result as two bytes, waiting on Busy.
        send("alu_lo", 8'hF0, 1'b0, 1'b0, 10, 11'b0_00001111_1_1, 8'h00, -1);
        for (int k = 0; k < 40 && Busy; k++) tick();
        chk("alu gap busy", Busy, 1'b0);
        send("alu_hi", 8'h12, 1'b0, 1'b0, 10, 11'b0_01001000_1_1, 8'h00, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
